// File: rtl/iomem_router_pkg.sv
// Shared definitions for the iomem router: slot field, status layout, FSM encoding.
package iomem_router_pkg;

  localparam int SLOT_LSB = 20;
  localparam int SLOT_MSB = 23;
  localparam logic [3:0] STATUS_SLOT = 4'hF;

  localparam int ST_TO_BIT    = 0;
  localparam int ST_UNMAP_BIT = 1;
  localparam int ST_SLOT_LSB  = 4;
  localparam int ST_CNT_LSB   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/iomem_router_watchdog.sv
// Per-access timeout: loaded on clear, counts down while enabled, flags the last allowed cycle.
module iomem_watchdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LOAD = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (!resetn)
      count <= '0;
    else if (clr)
      count <= LOAD;
    else if (en && count != '0)
      count <= count - 1'b1;
  end

  // Zero while enabled means s_valid has now been held TIMEOUT cycles.
  assign expired = en && (count == '0);

endmodule

// File: rtl/iomem_router.sv
// Routes picosoc iomem accesses in the BASE window to peripheral slots, with timeout and sticky status.
//  state  | meaning
//  IDLE   | waiting for an m_valid hit in the BASE window
//  ACCESS | s_valid[sel] held, waiting for s_ready[sel] or timeout
//  RESP   | one-cycle m_ready pulse with m_rdata
module iomem_router
  import iomem_router_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter logic [7:0]  BASE      = 8'h03,
  parameter int          TIMEOUT   = 255,
  parameter int          TO_W      = 8,
  parameter logic [31:0] TO_DATA   = 32'hFFFF_FFFF
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [3:0]             m_wstrb,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  output logic [31:0]            m_rdata,
  output logic [NUM_SLOTS-1:0]   s_valid,
  input  logic [NUM_SLOTS-1:0]   s_ready,
  output logic [19:0]            s_addr,
  output logic [3:0]             s_wstrb,
  output logic [31:0]            s_wdata,
  input  logic [32*NUM_SLOTS-1:0] s_rdata,
  output logic                   err_irq
);

  state_t state;
  logic [3:0] sel;
  logic [3:0] m_sel;
  logic       hit, mapped, slot_ready, expired;
  logic [NUM_SLOTS-1:0] onehot;
  logic [31:0] slot_rdata, status_word;
  logic       st_to, st_unmap;
  logic [3:0] st_slot;
  logic [7:0] st_cnt;

  assign m_sel  = m_addr[SLOT_MSB:SLOT_LSB];
  assign hit    = m_valid && (m_addr[31:24] == BASE);
  assign mapped = int'(m_sel) < NUM_SLOTS;

  // s_valid is one-hot on sel, so it doubles as the ready/rdata mask.
  always_comb begin
    onehot     = '0;
    slot_rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      onehot[i] = (int'(m_sel) == i);
      if (s_valid[i])
        slot_rdata = slot_rdata | s_rdata[32*i +: 32];
    end
    slot_ready = |(s_ready & s_valid);
  end

  always_comb begin
    status_word = '0;
    status_word[ST_TO_BIT]    = st_to;
    status_word[ST_UNMAP_BIT] = st_unmap;
    status_word[ST_SLOT_LSB +: 4] = st_slot;
    status_word[ST_CNT_LSB  +: 8] = st_cnt;
  end

  assign err_irq = st_to | st_unmap;

  iomem_watchdog #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK     (CLK),
    .resetn  (resetn),
    .clr     (state == ST_IDLE && hit && mapped),
    .en      (state == ST_ACCESS),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      sel      <= '0;
      m_ready  <= 1'b0;
      m_rdata  <= '0;
      s_valid  <= '0;
      s_addr   <= '0;
      s_wstrb  <= '0;
      s_wdata  <= '0;
      st_to    <= 1'b0;
      st_unmap <= 1'b0;
      st_slot  <= '0;
      st_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          m_ready <= 1'b0;
          m_rdata <= '0;
          if (hit) begin
            sel     <= m_sel;
            s_addr  <= m_addr[19:0];
            s_wstrb <= m_wstrb;
            s_wdata <= m_wdata;
            m_ready <= !mapped;
            if (mapped) begin
              s_valid <= onehot;
              state   <= ST_ACCESS;
            end else if (m_sel == STATUS_SLOT) begin
              m_rdata <= status_word;
              state   <= ST_RESP;
              if (m_wstrb[0] && m_wdata[ST_TO_BIT])    st_to    <= 1'b0;
              if (m_wstrb[0] && m_wdata[ST_UNMAP_BIT]) st_unmap <= 1'b0;
              if (m_wstrb[1])                          st_cnt   <= '0;
            end else begin
              m_rdata  <= TO_DATA;
              st_unmap <= 1'b1;
              state    <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (slot_ready) begin
            s_valid <= '0;
            m_rdata <= slot_rdata;
            m_ready <= 1'b1;
            state   <= ST_RESP;
          end else if (expired) begin
            s_valid <= '0;
            m_rdata <= TO_DATA;
            m_ready <= 1'b1;
            st_to   <= 1'b1;
            st_slot <= sel;
            if (st_cnt != 8'hFF) st_cnt <= st_cnt + 8'd1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          m_ready <= 1'b0;
          m_rdata <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_router.sv
// Directed bench for iomem_router with NUM_SLOTS=4, TIMEOUT=4.
module tb_iomem_router;

  logic         CLK = 1'b0;
  logic         resetn;
  logic         m_valid;
  logic         m_ready;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [19:0]  s_addr;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic         err_irq;

  int vectors = 0;
  int errs    = 0;

  iomem_router #(.NUM_SLOTS(4), .BASE(8'h03), .TIMEOUT(4), .TO_W(8), .TO_DATA(32'hFFFF_FFFF)) dut (
    .CLK(CLK), .resetn(resetn), .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_rdata(s_rdata), .err_irq(err_irq)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
    m_valid = 1'b1;
    m_addr  = a;
    m_wstrb = ws;
    m_wdata = wd;
  endtask

  task automatic drop();
    m_valid = 1'b0;
    m_wstrb = 4'h0;
    s_ready = 4'h0;
  endtask

  initial begin
    resetn = 1'b0; m_valid = 1'b0; m_wstrb = 4'h0; m_addr = '0; m_wdata = '0;
    s_ready = 4'h0; s_rdata = '0;
    step(); step();
    chk("rst_m_ready", 32'(m_ready), 32'h0);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_err_irq", 32'(err_irq), 32'h0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    resetn = 1'b1;
    step();

    // 1: slot 1 read, ready at cycle 3
    s_rdata[63:32] = 32'h1234_5678;
    start(32'h0310_0000, 4'h0, 32'h0);
    step();
    chk("t1_sv_c1", 32'(s_valid), 32'h2);
    chk("t1_mr_c1", 32'(m_ready), 32'h0);
    step();
    chk("t1_sv_c2", 32'(s_valid), 32'h2);
    step();
    chk("t1_sv_c3", 32'(s_valid), 32'h2);
    s_ready = 4'b0010;
    step();
    chk("t1_mr_c4", 32'(m_ready), 32'h1);
    chk("t1_rd_c4", m_rdata, 32'h1234_5678);
    chk("t1_sv_c4", 32'(s_valid), 32'h0);
    drop();
    step();
    chk("t1_mr_c5", 32'(m_ready), 32'h0);
    chk("t1_rd_c5", m_rdata, 32'h0);

    // 2: slot 2 write, shared bus stable while master inputs change
    s_rdata[95:64] = 32'h0000_2222;
    start(32'h0320_0010, 4'b0101, 32'hAABB_CCDD);
    step();
    chk("t2_saddr", 32'(s_addr), 32'h0_0010);
    chk("t2_swstrb", 32'(s_wstrb), 32'h5);
    chk("t2_swdata", s_wdata, 32'hAABB_CCDD);
    m_addr = 32'h0310_FFFF; m_wdata = 32'h0; m_wstrb = 4'hF;
    step();
    chk("t2_saddr_c2", 32'(s_addr), 32'h0_0010);
    chk("t2_swstrb_c2", 32'(s_wstrb), 32'h5);
    chk("t2_swdata_c2", s_wdata, 32'hAABB_CCDD);
    chk("t2_mr_c2", 32'(m_ready), 32'h0);
    s_ready = 4'b0100;
    step();
    chk("t2_mr_c3", 32'(m_ready), 32'h1);
    drop();
    step();
    chk("t2_mr_c4", 32'(m_ready), 32'h0);

    // 3: slot 3 never ready -> timeout after 4 cycles of s_valid
    start(32'h0330_0000, 4'h0, 32'h0);
    step(); step(); step(); step();
    chk("t3_sv_c4", 32'(s_valid), 32'h8);
    chk("t3_mr_c4", 32'(m_ready), 32'h0);
    step();
    chk("t3_mr_c5", 32'(m_ready), 32'h1);
    chk("t3_rd_c5", m_rdata, 32'hFFFF_FFFF);
    chk("t3_sv_c5", 32'(s_valid), 32'h0);
    chk("t3_irq", 32'(err_irq), 32'h1);
    drop();
    step();
    start(32'h03F0_0000, 4'h0, 32'h0);
    step();
    chk("t3_st_mr", 32'(m_ready), 32'h1);
    chk("t3_status", m_rdata, 32'h0000_0131);
    drop();
    step();

    // 4a: ready in the exact timeout cycle wins
    s_rdata[127:96] = 32'hCAFE_0003;
    start(32'h0330_0000, 4'h0, 32'h0);
    step(); step(); step(); step();
    s_ready = 4'b1000;
    step();
    chk("t4_mr", 32'(m_ready), 32'h1);
    chk("t4_rd", m_rdata, 32'hCAFE_0003);
    drop();
    step();
    start(32'h03F0_0000, 4'h0, 32'h0);
    step();
    chk("t4_status", m_rdata, 32'h0000_0131);
    drop();
    step();

    // 4b: s_ready[0] during slot-2 access is ignored
    s_rdata[31:0] = 32'hDEAD_0000;
    start(32'h0320_0000, 4'h0, 32'h0);
    step();
    s_ready = 4'b0001;
    step();
    chk("t4b_mr_c2", 32'(m_ready), 32'h0);
    chk("t4b_sv_c2", 32'(s_valid), 32'h4);
    s_ready = 4'b0100;
    step();
    chk("t4b_mr_c3", 32'(m_ready), 32'h1);
    chk("t4b_rd_c3", m_rdata, 32'h0000_2222);
    drop();
    step();

    // 5: unmapped slot, then status clear
    start(32'h0370_0000, 4'h0, 32'h0);
    step();
    chk("t5_mr_c1", 32'(m_ready), 32'h1);
    chk("t5_rd_c1", m_rdata, 32'hFFFF_FFFF);
    chk("t5_sv_c1", 32'(s_valid), 32'h0);
    drop();
    step();
    start(32'h03F0_0000, 4'h0, 32'h0);
    step();
    chk("t5_status", m_rdata, 32'h0000_0133);
    drop();
    step();
    start(32'h03F0_0000, 4'b0011, 32'h0000_0003);
    step();
    chk("t5_wr_mr", 32'(m_ready), 32'h1);
    drop();
    step();
    chk("t5_irq", 32'(err_irq), 32'h0);
    start(32'h03F0_0000, 4'h0, 32'h0);
    step();
    chk("t5_status_clr", m_rdata, 32'h0000_0030);
    drop();
    step();

    // 6: reset mid-access, then off-window request
    start(32'h0310_0000, 4'h0, 32'h0);
    step();
    chk("t6_sv_c1", 32'(s_valid), 32'h2);
    resetn = 1'b0;
    step();
    chk("t6_sv_rst", 32'(s_valid), 32'h0);
    chk("t6_mr_rst", 32'(m_ready), 32'h0);
    resetn = 1'b1;
    drop();
    step();
    chk("t6_mr_post", 32'(m_ready), 32'h0);
    start(32'h0200_0000, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_off_mr", 32'(m_ready), 32'h0);
      chk("t6_off_sv", 32'(s_valid), 32'h0);
    end
    drop();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
